id_issue_ctrl: RTL and testbench
================================

ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: if_valid  input  1 / if_ready  output  1 / if_instr  input  32 / if_pc  input  32  (fetch handshake).
REQ-004 SHALL have ports: id_instr  output  32 / id_pc  output  32  (held instruction, drives the combinational decoder).
REQ-005 SHALL have ports: dec_rs1, dec_rs2, dec_rd  input  5 each / dec_opcode  input  7  (decoder fields of id_instr).
REQ-006 SHALL have ports: ex_valid  output  1 / ex_ready  input  1 / ex_instr  output  32 / ex_pc  output  32  (issue handshake).
REQ-007 SHALL have ports: wb_valid  input  1 / wb_rd  input  5  (writeback retire) / flush  input  1  (branch redirect).
REQ-008 SHALL have ports: state_o  output  2  (debug FSM state) / stall_cycles  output  16  (hazard perf counter).

Function
REQ-009 SHALL hold one instruction in an ID register (id_valid, id_instr, id_pc); if_ready = (~id_valid | issue) & ~flush.
REQ-010 SHALL capture if_instr/if_pc when if_valid & if_ready; captured instruction visible on id_* next cycle, earliest issue that cycle (1-cycle latency).
REQ-011 SHALL classify: uses_rs1 = opcode not LUI(0110111)/AUIPC(0010111)/JAL(1101111); uses_rs2 = R(0110011)/S(0100011)/B(1100011); writes_rd = R, I-ALU(0010011), IW(0011011), LUI, AUIPC, JAL, JALR(1100111), LOAD(0000011), and dec_rd != 0.
REQ-012 SHALL keep a 32-bit busy scoreboard; bit 0 permanently 0.
REQ-013 SHALL flag hazard = id_valid & ((uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (writes_rd & busy[rd])), using registered busy only (no same-cycle wb bypass).
REQ-014 SHALL drive ex_valid = id_valid & ~hazard & ~flush; issue = ex_valid & ex_ready; ex_instr/ex_pc = id_instr/id_pc.
REQ-015 SHALL set busy[dec_rd] on issue when the instruction is a tracked writer (see REQ-022); SHALL clear busy[wb_rd] on wb_valid; same-register set and clear in one cycle -> set wins.
REQ-016 SHALL implement FSM EMPTY (~id_valid), READY (id_valid & ~hazard), STALL (id_valid & hazard); state_o = 0/1/2 respectively, computed from next-cycle registers.
REQ-017 Transitions: EMPTY->READY/STALL on capture; READY->EMPTY on issue without capture; READY->READY on issue with capture or ex_ready=0; STALL->READY when blocking busy bits clear; any state->EMPTY on flush.
REQ-018 flush SHALL invalidate the ID register, block capture and issue that cycle, and leave the scoreboard untouched (in-flight writers still retire).
REQ-019 stall_cycles SHALL increment each cycle state is STALL, saturating at 16'hFFFF; ex_ready=0 backpressure alone does not count.
REQ-020 wb_valid with wb_rd=0 SHALL have no effect.

Reset
REQ-021 On reset: id_valid=0, id_instr=0, id_pc=0, busy=0, stall_cycles=0, state EMPTY; hence if_ready=1, ex_valid=0, state_o=0; reset overrides flush, capture and issue in the same cycle.

Configuration
REQ-022 Macro ID_BYPASS_EN: defined -> only LOAD instructions set busy (EX/MEM bypass covers ALU results, only load-use stalls); undefined -> every writes_rd instruction sets busy.

Structure
REQ-023 Shared package riscv_pkg SHALL hold opcode constants (OP_R, OP_IMM, OP_IMMW, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR) and the id_state_t enum.
REQ-024 Scoreboard SHALL be a sub-module id_scoreboard (set port, clear port, two read ports plus rd read port).

Verification
REQ-025 Reset then if_valid with ADDI x1,x0,5 (00500093) -> captured, ex_valid=1 next cycle, issue with ex_ready=1; busy[1]=1 without ID_BYPASS_EN, 0 with it.
REQ-026 LD x5,0(x2) issued, then ADD x6,x5,x7 -> STALL, ex_valid=0, stall_cycles increments each cycle until wb_valid wb_rd=5, issue one cycle after retire.
REQ-027 ex_ready=0 for 3 cycles with READY instruction -> if_ready=0, instruction held, stall_cycles unchanged.
REQ-028 flush asserted while in STALL -> next cycle EMPTY, no issue, busy bits unchanged, subsequent capture works.
REQ-029 Issue writing x9 and wb_valid wb_rd=9 same cycle -> busy[9]=1 afterwards; wb_rd=0 or writer with rd=0 -> busy unchanged.
REQ-030 Force 65540 stall cycles -> stall_cycles holds 16'hFFFF; reset mid-stall -> all outputs at REQ-021 values next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants, the ID-stage state enum and the register-use classifier.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMMW   = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_READY = 2'd1,
    ST_STALL = 2'd2
  } id_state_t;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } reg_use_t;

  function automatic reg_use_t classify(input logic [6:0] op, input logic [4:0] rd);
    reg_use_t u;
    u.uses_rs1  = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    u.uses_rs2  = (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    u.writes_rd = (op == OP_R || op == OP_IMM || op == OP_IMMW || op == OP_LUI ||
                   op == OP_AUIPC || op == OP_JAL || op == OP_JALR || op == OP_LOAD) &&
                  (rd != 5'd0);
    return u;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Register busy scoreboard: one set port, one clear port, rs1/rs2/rd read ports.
// busy_nxt exposes the value the scoreboard will hold after this edge.
module id_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  input  logic [4:0]  rd_idx,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy,
  output logic [31:0] busy_nxt
);

  logic [31:0] busy_q;

  // Clear is applied before set so a same-register set and clear leaves the bit set.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign rs1_busy = busy_q[rs1_idx];
  assign rs2_busy = busy_q[rs2_idx];
  assign rd_busy  = busy_q[rd_idx];

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage holding register, scoreboard hazard check and issue control.
// Define ID_BYPASS_EN to track only loads in the scoreboard (ALU results are bypassed).
module id_issue_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic [6:0]  dec_opcode,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_pc,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cycles
);

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [15:0] stall_q;
  id_state_t   state_q, state_d;

  reg_use_t    cur_use, nxt_use;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic [31:0] busy_nxt;
  logic        hazard, nxt_hazard;
  logic        issue, capture, set_en;

  assign cur_use = classify(dec_opcode, dec_rd);
  assign hazard  = id_valid_q & ((cur_use.uses_rs1 & rs1_busy) |
                                 (cur_use.uses_rs2 & rs2_busy) |
                                 (cur_use.writes_rd & rd_busy));

  assign ex_valid = id_valid_q & ~hazard & ~flush;
  assign issue    = ex_valid & ex_ready;
  assign if_ready = (~id_valid_q | issue) & ~flush;
  assign capture  = if_valid & if_ready;

`ifdef ID_BYPASS_EN
  assign set_en = issue & cur_use.writes_rd & (dec_opcode == OP_LOAD);
`else
  assign set_en = issue & cur_use.writes_rd;
`endif

  id_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_idx  (dec_rd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .rs1_idx  (dec_rs1),
    .rs2_idx  (dec_rs2),
    .rd_idx   (dec_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .busy_nxt (busy_nxt)
  );

  assign id_valid_d = capture | (id_valid_q & ~issue & ~flush);
  assign id_instr_d = capture ? if_instr : id_instr_q;
  assign id_pc_d    = capture ? if_pc    : id_pc_q;

  // The state register reflects the next-cycle contents, so the held instruction is
  // re-decoded here against the scoreboard's next value (standard field positions).
  assign nxt_use    = classify(id_instr_d[6:0], id_instr_d[11:7]);
  assign nxt_hazard = (nxt_use.uses_rs1  & busy_nxt[id_instr_d[19:15]]) |
                      (nxt_use.uses_rs2  & busy_nxt[id_instr_d[24:20]]) |
                      (nxt_use.writes_rd & busy_nxt[id_instr_d[11:7]]);

  always_comb begin
    state_d = ST_EMPTY;
    if (id_valid_d) state_d = nxt_hazard ? ST_STALL : ST_READY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      if (state_q == ST_STALL && stall_q != '1) stall_q <= stall_q + 16'd1;
    end
  end

  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign ex_instr     = id_instr_q;
  assign ex_pc        = id_pc_q;
  assign state_o      = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Self-checking bench for id_issue_ctrl: table-driven vectors plus directed corner sequences.
module tb_id_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset, if_valid, if_ready, ex_valid, ex_ready, wb_valid, flush;
  logic [31:0] if_instr, if_pc, id_instr, id_pc, ex_instr, ex_pc;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic [6:0]  dec_opcode;
  logic [1:0]  state_o;
  logic [15:0] stall_cycles;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

`ifdef ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] I_ADDI_X1  = 32'h00500093;
  localparam logic [31:0] I_LD_X5    = 32'h00013283;
  localparam logic [31:0] I_ADD_X6   = 32'h00728333;
  localparam logic [31:0] I_ADD_X10  = 32'h00008533;
  localparam logic [31:0] I_ADDI_X12 = 32'h00300613;
  localparam logic [31:0] I_NOP      = 32'h00000013;
  localparam logic [31:0] I_LD_X9    = 32'h00003483;
  localparam logic [31:0] I_ADD_X11  = 32'h000485b3;
  localparam logic [31:0] I_LD_X0    = 32'h00003003;
  localparam logic [31:0] I_ADD_X13  = 32'h000006b3;

  always #5 clk = ~clk;

  assign dec_opcode = id_instr[6:0];
  assign dec_rd     = id_instr[11:7];
  assign dec_rs1    = id_instr[19:15];
  assign dec_rs2    = id_instr[24:20];

  id_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .id_instr(id_instr), .id_pc(id_pc),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_opcode(dec_opcode),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .state_o(state_o), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic        ifv;
    logic [31:0] instr;
    logic        exr;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        e_ifr;
    logic        e_exv;
    logic [1:0]  e_st;
    logic [15:0] e_stall;
    logic [31:0] e_exi;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ifv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic exr, input logic wbv, input logic [4:0] wrd,
                       input logic fl);
    if_valid = ifv; if_instr = ins; if_pc = pc;
    ex_ready = exr; wb_valid = wbv; wb_rd = wrd; flush = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);

    // Load-use stall then backpressure, same for both builds (loads are always tracked)
    tbl[0]  = '{1'b1, I_LD_X5,    1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 2'd0, 16'd0, 32'd0};
    tbl[1]  = '{1'b1, I_ADD_X6,   1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 2'd1, 16'd0, I_LD_X5};
    tbl[2]  = '{1'b0, 32'd0,      1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd2, 16'd0, I_ADD_X6};
    tbl[3]  = '{1'b0, 32'd0,      1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd2, 16'd1, I_ADD_X6};
    tbl[4]  = '{1'b0, 32'd0,      1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 2'd2, 16'd2, I_ADD_X6};
    tbl[5]  = '{1'b0, 32'd0,      1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 2'd1, 16'd3, I_ADD_X6};
    tbl[6]  = '{1'b0, 32'd0,      1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 2'd0, 16'd3, I_ADD_X6};
    tbl[7]  = '{1'b1, I_ADDI_X12, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 2'd0, 16'd3, I_ADD_X6};
    tbl[8]  = '{1'b1, I_NOP,      1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'd1, 16'd3, I_ADDI_X12};
    tbl[9]  = '{1'b1, I_NOP,      1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'd1, 16'd3, I_ADDI_X12};
    tbl[10] = '{1'b1, I_NOP,      1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'd1, 16'd3, I_ADDI_X12};
    tbl[11] = '{1'b0, 32'd0,      1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 2'd1, 16'd3, I_ADDI_X12};
    tbl[12] = '{1'b0, 32'd0,      1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 2'd0, 16'd3, I_ADDI_X12};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ifv, tbl[i].instr, 32'h8000_0000 + 32'(i) * 4, tbl[i].exr,
            tbl[i].wbv, tbl[i].wbrd, 1'b0);
      chk($sformatf("v%0d_if_ready", i), {31'd0, if_ready}, {31'd0, tbl[i].e_ifr});
      chk($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, tbl[i].e_exv});
      chk($sformatf("v%0d_state", i), {30'd0, state_o}, {30'd0, tbl[i].e_st});
      chk($sformatf("v%0d_stall", i), {16'd0, stall_cycles}, {16'd0, tbl[i].e_stall});
      chk($sformatf("v%0d_ex_instr", i), ex_instr, tbl[i].e_exi);
      step();
    end

    // ADDI x1 issue, then probe busy[1] with a reader of x1
    do_reset();
    drive(1'b1, I_ADDI_X1, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("addi_if_ready", {31'd0, if_ready}, 32'd1);
    step();
    drive(1'b1, I_ADD_X10, 32'h104, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("addi_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_ex_instr", ex_instr, I_ADDI_X1);
    chk("addi_ex_pc", ex_pc, 32'h100);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("addi_busy1_state", {30'd0, state_o}, BYP ? 32'd1 : 32'd2);
    chk("addi_busy1_ex_valid", {31'd0, ex_valid}, BYP ? 32'd1 : 32'd0);
    chk("addi_ex_pc2", ex_pc, 32'h104);

    // Flush while stalled
    do_reset();
    drive(1'b1, I_LD_X5, 32'h200, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b1, I_ADD_X6, 32'h204, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b1, I_ADD_X6, 32'h300, 1'b1, 1'b0, 5'd0, 1'b1);
    chk("fl_pre_state", {30'd0, state_o}, 32'd2);
    chk("fl_if_ready", {31'd0, if_ready}, 32'd0);
    chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    step();
    drive(1'b1, I_ADD_X6, 32'h300, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("fl_post_state", {30'd0, state_o}, 32'd0);
    chk("fl_post_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_post_if_ready", {31'd0, if_ready}, 32'd1);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b1, 5'd5, 1'b0);
    chk("fl_busy5_kept", {30'd0, state_o}, 32'd2);
    chk("fl_recap_pc", id_pc, 32'h300);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("fl_issue_state", {30'd0, state_o}, 32'd1);
    chk("fl_issue_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("fl_stall_count", {16'd0, stall_cycles}, 32'd2);

    // Set/clear collision on x9, wb to x0, writer with rd=x0
    do_reset();
    drive(1'b1, I_LD_X9, 32'h400, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b1, 5'd9, 1'b0);
    chk("col_ex_valid", {31'd0, ex_valid}, 32'd1);
    step();
    drive(1'b1, I_ADD_X11, 32'h404, 1'b1, 1'b1, 5'd0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("col_busy9_state", {30'd0, state_o}, 32'd2);
    chk("col_busy9_ex_valid", {31'd0, ex_valid}, 32'd0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b1, 5'd9, 1'b0);
    chk("col_still_stall", {30'd0, state_o}, 32'd2);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("col_release", {31'd0, ex_valid}, 32'd1);
    step();
    drive(1'b1, I_LD_X0, 32'h500, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b1, I_ADD_X13, 32'h504, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("rd0_ex_valid", {31'd0, ex_valid}, 32'd1);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("rd0_no_busy_state", {30'd0, state_o}, 32'd1);

    // Counter saturation then reset mid-stall
    do_reset();
    drive(1'b1, I_LD_X5, 32'h600, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b1, I_ADD_X6, 32'h604, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 65540; c++) step();
    chk("sat_stall", {16'd0, stall_cycles}, 32'h0000_FFFF);
    chk("sat_state", {30'd0, state_o}, 32'd2);
    reset = 1'b1;
    drive(1'b1, I_NOP, 32'h700, 1'b1, 1'b1, 5'd5, 1'b1);
    step();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("mid_rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("mid_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("mid_rst_state", {30'd0, state_o}, 32'd0);
    chk("mid_rst_stall", {16'd0, stall_cycles}, 32'd0);
    chk("mid_rst_id_pc", id_pc, 32'd0);
    drive(1'b1, I_ADD_X6, 32'h800, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("mid_rst_busy_clear", {30'd0, state_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
